morse_keyer: RTL and testbench
==============================

Name: morse_keyer

Overview:
- Downstream of the ASCII-to-Morse translator. Accepts one 20-bit left-aligned Morse pattern per character through a valid/ready handshake.
- Plays the pattern out MSB-first on a single key line, one bit per Morse time unit.
- Appends inter-character or word spacing, so a tone generator or LED driver can consume `key_out` directly.
- Pattern encoding: dot = 2'b10, dash = 4'b1110, element trailing zero = inter-element gap, unused low bits = 0, all-zero pattern = space or unknown character.

Parameters:
- UNIT_CYCLES, 1200000: clock cycles per Morse time unit; must be >= 1; tick every cycle when 1.
- CHAR_GAP_UNITS, 3: key-low units appended after the last nonzero bit of a non-empty pattern.
- WORD_GAP_UNITS, 4: key-low units emitted for an all-zero pattern. Added to the preceding 3-unit character gap, this gives the standard 7-unit word gap.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_pattern holds a character to send
- in_ready  out  1  keyer can accept a character (high only in IDLE)
- in_pattern  in  20  left-aligned Morse pattern, bit 19 sent first
- key_out  out  1  registered key line; 1 = tone/on
- busy  out  1  high in SEND or GAP
- char_done  out  1  one-cycle pulse in the final cycle of each character's gap

Behaviour:
- Reset (synchronous, checked every edge, overrides everything including mid-character):
  - state = IDLE, key_out = 0, busy = 0, char_done = 0, in_ready = 1.
  - Shift register, unit counter and gap counter cleared.
- Accept rule: accept on a rising edge with in_valid && in_ready. in_valid while busy is ignored, and the pattern is not queued.
- On accept:
  - in_pattern == 0: go to GAP with gap count = WORD_GAP_UNITS.
  - Otherwise: load the shift register with in_pattern, clear the unit counter, go to SEND.
- Unit timer:
  - Counter runs 0..UNIT_CYCLES-1, width $clog2(UNIT_CYCLES), minimum 1 bit.
  - tick = (count == UNIT_CYCLES-1). Counter resets to 0 on every tick and on entry to SEND/GAP.
- SEND:
  - key_out = shift register bit 19, registered, so key_out changes one cycle after the accepting edge.
  - On tick, shift left by 1 with zero fill.
  - If the shifted value == 0, go to GAP with gap count = CHAR_GAP_UNITS. The element's trailing zero is absorbed into the character gap, not sent separately.
  - Each bit is held exactly UNIT_CYCLES cycles.
- GAP:
  - key_out = 0.
  - On tick, decrement gap count. char_done = 1 in the last cycle of the last unit.
  - Next state IDLE, with in_ready = 1 the cycle after char_done.
- Latency: a non-empty pattern whose last 1 sits at bit index b occupies (20-b) bit units plus CHAR_GAP_UNITS gap units, times UNIT_CYCLES cycles, measured from the cycle after accept to the cycle before in_ready returns.
- Back-to-back: in_valid held high means the next accept occurs on the first IDLE cycle, giving 1 idle cycle between characters.
- Widths: gap counter 3 bits; CHAR_GAP_UNITS and WORD_GAP_UNITS are each required to be 1..7.
- No combinational path from in_valid/in_pattern to any output.

Test Plan (UNIT_CYCLES=2 unless stated; accept at edge k):
- 'S' pattern 20'hA8000:
  - key_out = 1,0,1,0,1 for 2 cycles each (cycles k+1..k+10), then 0 for 6 cycles.
  - char_done high at cycle k+16; in_ready high at k+17.
- 'T' pattern 20'hE0000: key_out high 6 cycles, low 6 cycles, char_done once, busy high for exactly 12 cycles.
- '0' pattern 20'hEEEEE: 19 bit units (last trailing zero dropped) plus 3 gap units, so busy = 44 cycles; key_out high-run lengths are 6,6,6,6,6 cycles, separated by 2-cycle lows.
- All-zero pattern: no key activity, busy 8 cycles, single char_done; then in_valid with 20'hA8000 held across the whole run is accepted exactly once per idle window.
- Reset mid-SEND: assert rst during the second dot of 'S' -> next cycle key_out=0, busy=0, in_ready=1, no char_done; a fresh 'T' then plays from its start.
- UNIT_CYCLES=1 build, 'A'-style pattern 20'hB8000 -> key_out 1,0,1,1,1 one cycle each, 3 gap cycles, char_done at gap end.

Source files
------------

// File: rtl/morse_keyer.sv
// Morse keyer: plays a left-aligned 20-bit Morse pattern MSB-first on key_out,
// one bit per time unit, then appends character or word spacing.
//
//   state | meaning
//   IDLE  | waiting for a character, in_ready high
//   SEND  | shifting pattern bits out on key_out
//   GAP   | key low for the character/word gap, char_done on final cycle
module morse_keyer #(
    parameter int UNIT_CYCLES    = 1200000,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_pattern,
    output logic        key_out,
    output logic        busy,
    output logic        char_done
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [19:0]     shreg, shreg_nxt, shifted;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      gap, gap_nxt;
    logic            key_nxt;
    logic            tick;

    assign tick     = (cnt == CW'(UNIT_CYCLES - 1));
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign shifted  = {shreg[18:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            gap     <= '0;
            key_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            gap     <= gap_nxt;
            key_out <= key_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        gap_nxt   = gap;
        cnt_nxt   = tick ? '0 : cnt + CW'(1);
        char_done = 1'b0;
        case (state)
            IDLE: begin
                // Holding the counter at zero here gives every SEND/GAP a fresh unit.
                cnt_nxt = '0;
                if (in_valid) begin
                    if (in_pattern == 20'd0) begin
                        state_nxt = GAP;
                        gap_nxt   = 3'(WORD_GAP_UNITS);
                    end else begin
                        state_nxt = SEND;
                        shreg_nxt = in_pattern;
                    end
                end
            end
            SEND: begin
                if (tick) begin
                    shreg_nxt = shifted;
                    // The last element's trailing zero is folded into the gap.
                    if (shifted == 20'd0) begin
                        state_nxt = GAP;
                        gap_nxt   = 3'(CHAR_GAP_UNITS);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    gap_nxt = gap - 3'd1;
                    if (gap == 3'd1) begin
                        char_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        key_nxt = (state_nxt == SEND) && shreg_nxt[19];
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer: table of characters on a 2-cycle-unit build,
// plus hand-written back-to-back, mid-character reset and 1-cycle-unit cases.
module tb_morse_keyer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid2, valid1;
    logic [19:0] pattern;
    logic        rdy2, key2, busy2, done2;
    logic        rdy1, key1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    morse_keyer #(.UNIT_CYCLES(2), .CHAR_GAP_UNITS(3), .WORD_GAP_UNITS(4)) u_u2 (
        .clk(clk), .rst(rst), .in_valid(valid2), .in_ready(rdy2),
        .in_pattern(pattern), .key_out(key2), .busy(busy2), .char_done(done2)
    );

    morse_keyer #(.UNIT_CYCLES(1), .CHAR_GAP_UNITS(3), .WORD_GAP_UNITS(4)) u_u1 (
        .clk(clk), .rst(rst), .in_valid(valid1), .in_ready(rdy1),
        .in_pattern(pattern), .key_out(key1), .busy(busy1), .char_done(done1)
    );

    typedef struct {
        logic [19:0] pat;
        int          busy;
        int          high;
        string       name;
    } vec_t;

    vec_t tbl [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Send one character and observe 50 cycles; key_out is compared with the
    // pattern bit that should be on air, held unit cycles each, up to the last 1.
    task automatic run_char(input bit use_u1, input logic [19:0] p, input int unit,
                            input int exp_busy, input int exp_high, input string name);
        int nbusy = 0, nhigh = 0, ndone = 0, done_at = 0, ready_at = 0, bad = 0;
        int last = -1, span, w = 0;
        logic k, b, d, r, e;
        while (!(use_u1 ? rdy1 : rdy2) && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s wait_ready timed out", name);
        end
        for (int i = 19; i >= 0; i--) if (p[i]) last = i;
        span = (last < 0) ? 0 : unit * (20 - last);
        pattern = p;
        if (use_u1) valid1 = 1'b1; else valid2 = 1'b1;
        step();
        valid1 = 1'b0;
        valid2 = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            k = use_u1 ? key1  : key2;
            b = use_u1 ? busy1 : busy2;
            d = use_u1 ? done1 : done2;
            r = use_u1 ? rdy1  : rdy2;
            e = (j <= span) ? p[19 - (j - 1) / unit] : 1'b0;
            if (k !== e) bad++;
            if (b) nbusy++;
            if (k) nhigh++;
            if (d) begin
                ndone++;
                done_at = j;
            end
            if (r && ready_at == 0) ready_at = j;
            step();
        end
        chk({name, " busy_cycles"}, nbusy, exp_busy);
        chk({name, " key_high_cycles"}, nhigh, exp_high);
        chk({name, " char_done_count"}, ndone, 1);
        chk({name, " char_done_cycle"}, done_at, exp_busy);
        chk({name, " ready_cycle"}, ready_at, exp_busy + 1);
        chk({name, " key_seq_bad_cycles"}, bad, 0);
    endtask

    initial begin
        int nready, ndone, nhigh;

        tbl[0] = '{20'hA8000, 16,  6, "S"};
        tbl[1] = '{20'hE0000, 12,  6, "T"};
        tbl[2] = '{20'hEEEEE, 44, 30, "0"};
        tbl[3] = '{20'h00000,  8,  0, "space"};
        tbl[4] = '{20'h80000,  8,  2, "E"};
        tbl[5] = '{20'h00001, 46,  2, "lsb_only"};

        rst     = 1'b1;
        valid1  = 1'b0;
        valid2  = 1'b0;
        pattern = 20'h00000;
        step();
        step();
        chk("reset key_out", int'(key2), 0);
        chk("reset busy", int'(busy2), 0);
        chk("reset in_ready", int'(rdy2), 1);
        chk("reset char_done", int'(done2), 0);
        rst = 1'b0;
        step();

        for (int t = 0; t < 6; t++)
            run_char(1'b0, tbl[t].pat, 2, tbl[t].busy, tbl[t].high, tbl[t].name);

        // in_valid held: space, then S accepted once per single idle cycle
        pattern = 20'h00000;
        valid2  = 1'b1;
        step();
        pattern = 20'hA8000;
        nready = 0;
        ndone  = 0;
        nhigh  = 0;
        for (int j = 1; j <= 42; j++) begin
            if (rdy2)  nready++;
            if (done2) ndone++;
            if (key2)  nhigh++;
            if (j == 42) valid2 = 1'b0;
            step();
        end
        chk("b2b idle_cycles", nready, 2);
        chk("b2b char_done_count", ndone, 3);
        chk("b2b key_high_cycles", nhigh, 12);

        // reset during the second dot of S
        pattern = 20'hA8000;
        valid2  = 1'b1;
        step();
        valid2 = 1'b0;
        for (int j = 1; j < 5; j++) step();
        chk("midrst key_before", int'(key2), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst key_out", int'(key2), 0);
        chk("midrst busy", int'(busy2), 0);
        chk("midrst in_ready", int'(rdy2), 1);
        chk("midrst char_done", int'(done2), 0);
        ndone = 0;
        nhigh = 0;
        for (int j = 0; j < 20; j++) begin
            if (done2) ndone++;
            if (key2)  nhigh++;
            step();
        end
        chk("midrst later_char_done", ndone, 0);
        chk("midrst later_key_high", nhigh, 0);
        run_char(1'b0, 20'hE0000, 2, 12, 6, "T_after_rst");

        run_char(1'b1, 20'hB8000, 1, 8, 4, "u1_A");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
